recording_saver: RTL



---
 rtl/recording_saver.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/recording_saver.sv
// Records timed (note, duration) events from the keyboard decoder into one of three
// slots. Exposes a registered read port and per-slot lengths for the playback stage.
module recording_saver #(
    parameter int TICK_DIV = 500000,
    parameter int ADDR_W   = 6,
    parameter int DUR_W    = 9
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic [6:0]             ascii,
    input  logic                   record_btn,
    input  logic [2:0]             slot_sel,
    input  logic [1:0]             rd_slot,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic [7+DUR_W-1:0]     rd_data,
    output logic [ADDR_W:0]        rd_len,
    output logic                   recording,
    output logic [1:0]             cur_slot
);
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ENTRY_W = 7 + DUR_W;
    localparam int DEPTH   = 3 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
    localparam logic [ADDR_W:0]   FULL     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, REC, FLUSH} state_t;

    state_t               state_q, state_d;
    logic [6:0]           asc_s1_q, asc_s2_q, asc_s3_q, note_acc_q;
    logic                 btn_s1_q, btn_s2_q, btn_s3_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [6:0]           note_q, note_d;
    logic [DUR_W-1:0]     dur_q, dur_d, dur_inc;
    logic [ADDR_W:0]      wptr_q, wptr_d;
    logic [1:0]           slot_q, slot_pick, rd_sel;
    logic [ADDR_W:0]      len_q [3];
    logic                 rec_q;
    logic [ENTRY_W-1:0]   rd_data_q;
    logic [ENTRY_W-1:0]   mem [DEPTH];

    logic                 press, tick, note_chg, we;
    logic [ENTRY_W-1:0]   wdata;

    assign press     = btn_s3_q & ~btn_s2_q;
    assign tick      = (state_q == REC) && (cnt_q == CNT_LAST);
    assign dur_inc   = (tick && dur_q != DUR_MAX) ? dur_q + DUR_W'(1) : dur_q;
    assign note_chg  = (note_acc_q != note_q);
    assign slot_pick = slot_sel[0] ? 2'd0 : (slot_sel[1] ? 2'd1 : 2'd2);
    assign cnt_d     = (state_q == REC && !tick) ? cnt_q + CNT_W'(1) : '0;
    assign rd_sel    = (rd_slot == 2'd3) ? 2'd0 : rd_slot;

    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        dur_d   = dur_q;
        wptr_d  = wptr_q;
        we      = 1'b0;
        wdata   = {note_q, dur_inc};
        case (state_q)
            IDLE: begin
                if (press && slot_sel != 3'b000) begin
                    state_d = REC;
                    note_d  = note_acc_q;
                    dur_d   = '0;
                    wptr_d  = '0;
                end
            end
            REC: begin
                dur_d = dur_inc;
                if (note_chg) begin
                    // a zero-length note is simply replaced, never stored
                    note_d = note_acc_q;
                    dur_d  = '0;
                    we     = (dur_inc != '0);
                end else if (dur_q == DUR_MAX) begin
                    we    = 1'b1;
                    dur_d = '0;
                end
                if (we) wptr_d = wptr_q + (ADDR_W+1)'(1);
                if (press || (we && wptr_d == FULL)) state_d = FLUSH;
            end
            FLUSH: begin
                wdata = {note_q, dur_q};
                if (dur_q != '0 && !wptr_q[ADDR_W]) begin
                    we     = 1'b1;
                    wptr_d = wptr_q + (ADDR_W+1)'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            asc_s1_q   <= '0;
            asc_s2_q   <= '0;
            asc_s3_q   <= '0;
            note_acc_q <= '0;
            btn_s1_q   <= 1'b1;
            btn_s2_q   <= 1'b1;
            btn_s3_q   <= 1'b1;
            cnt_q      <= '0;
            note_q     <= '0;
            dur_q      <= '0;
            wptr_q     <= '0;
            slot_q     <= '0;
            rec_q      <= 1'b0;
            for (int i = 0; i < 3; i++) len_q[i] <= '0;
        end else begin
            asc_s1_q <= ascii;
            asc_s2_q <= asc_s1_q;
            asc_s3_q <= asc_s2_q;
            if (asc_s2_q == asc_s3_q) note_acc_q <= asc_s2_q;
            btn_s1_q <= record_btn;
            btn_s2_q <= btn_s1_q;
            btn_s3_q <= btn_s2_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            note_q   <= note_d;
            dur_q    <= dur_d;
            wptr_q   <= wptr_d;
            rec_q    <= (state_d == REC);
            if (state_q == IDLE && state_d == REC) begin
                slot_q           <= slot_pick;
                len_q[slot_pick] <= '0;
            end
            if (state_q == FLUSH) len_q[slot_q] <= wptr_d;
        end
    end

    // entry RAM: no reset, one write port, registered read port
    always_ff @(posedge CLOCK_50) begin
        if (we) mem[{slot_q, wptr_q[ADDR_W-1:0]}] <= wdata;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) rd_data_q <= '0;
        else         rd_data_q <= mem[{rd_sel, rd_addr}];
    end

    assign rd_data   = rd_data_q;
    assign rd_len    = len_q[rd_sel];
    assign recording = rec_q;
    assign cur_slot  = slot_q;
endmodule
